// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared multi-cycle multiply/divide unit.
// Latches a mult/div op, starts the unit, stalls, then writes back.
module multdiv_ctrl #(
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] MULT_EXC = 32'd4,
  parameter logic [31:0] DIV_EXC  = 32'd5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        issue,
  input  logic        is_mult,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic        md_ready,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        status_we
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);
  localparam logic [4:0] EXC_RD = 5'd30;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          op_mult;
  logic [4:0]    rd_q;

  logic          fin_exc;
  logic [31:0]   exc_code;

  // Completion is an exception when the unit flags one or we time out
  always_comb begin
    fin_exc  = md_ready ? md_exception : 1'b1;
    exc_code = op_mult ? MULT_EXC : DIV_EXC;
  end

  // Accepting issue stalls combinationally so the op holds in execute
  always_comb begin
    stall = reset_n &
            (((state == IDLE) & issue & ~flush) |
             (state == START) |
             (state == WAIT));
    busy  = (state != IDLE);
  end

  // Sequencing FSM with registered start pulses and write-back
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      op_mult      <= 1'b0;
      rd_q         <= '0;
      md_a         <= '0;
      md_b         <= '0;
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      status_we    <= 1'b0;
    end else begin
      md_ctrl_mult <= 1'b0;
      md_ctrl_div  <= 1'b0;
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_data      <= '0;
      status_we    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (issue && !flush) begin
            op_mult      <= is_mult;
            md_a         <= operand_a;
            md_b         <= operand_b;
            rd_q         <= rd_in;
            md_ctrl_mult <= is_mult;
            md_ctrl_div  <= ~is_mult;
            state        <= START;
          end
        end
        START: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (flush) begin
            state <= IDLE;
          end else if (md_ready || (cnt == CNT_MAX)) begin
            wb_valid  <= fin_exc | (rd_q != 5'd0);
            wb_rd     <= fin_exc ? EXC_RD : rd_q;
            wb_data   <= fin_exc ? exc_code : md_result;
            status_we <= fin_exc;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl.
// Random mult/div ops against an arithmetic reference of the unit.
module tb_multdiv_ctrl;

  localparam int TO = 64;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        issue = 1'b0;
  logic        is_mult = 1'b0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic [4:0]  rd_in = '0;
  logic        flush = 1'b0;
  logic        md_ready = 1'b0;
  logic        md_exception = 1'b0;
  logic [31:0] md_result = '0;

  logic        md_ctrl_mult;
  logic        md_ctrl_div;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        stall;
  logic        busy;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        status_we;

  multdiv_ctrl #(
    .TIMEOUT (TO),
    .MULT_EXC(32'd4),
    .DIV_EXC (32'd5)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .issue       (issue),
    .is_mult     (is_mult),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .rd_in       (rd_in),
    .flush       (flush),
    .md_ctrl_mult(md_ctrl_mult),
    .md_ctrl_div (md_ctrl_div),
    .md_a        (md_a),
    .md_b        (md_b),
    .md_ready    (md_ready),
    .md_exception(md_exception),
    .md_result   (md_result),
    .stall       (stall),
    .busy        (busy),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .status_we   (status_we)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        st;
  } wb_t;

  wb_t exp_q[$];
  wb_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  stall_cnt = 0;
  int  start_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference unit: what a correct mult/div unit would return
  function automatic logic [31:0] unit_res(input logic m,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] p;
    if (m) begin
      p = {32'd0, a} * {32'd0, b};
      return p[31:0];
    end
    return $signed(a) / $signed(b);
  endfunction

  function automatic logic div_exc(input logic [31:0] a,
                                   input logic [31:0] b);
    return (b == 32'd0) ||
           (a == 32'h8000_0000 && b == 32'hffff_ffff);
  endfunction

  // Monitor: counts stall cycles and start pulses, checks write-backs
  always @(negedge clock) begin
    if (reset_n) begin
      if (stall) stall_cnt++;
      if (md_ctrl_mult || md_ctrl_div) start_cnt++;
      if (status_we && !wb_valid) chk("status_we_alone", status_we, 0);
      if (wb_valid) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", wb_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wb_rd", wb_rd, mon_e.rd);
          chk("wb_data", wb_data, mon_e.data);
          chk("wb_status", status_we, mon_e.st);
        end
      end
    end
  end

  // One op; enters just after a posedge in IDLE, leaves the same way.
  // lat: WAIT cycle with md_ready; fl: -1 none, 0 START, k WAIT cycle k
  task automatic run_op(input logic m, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input int lat, input int fl,
                        input logic fl_done, input logic mexc);
    int s0, p0, waits, exp_stall;
    logic ue, exc, flushed;
    logic [31:0] res;
    wb_t e;
    ue  = m ? mexc : div_exc(a, b);
    res = ue ? $urandom : unit_res(m, a, b);
    s0  = stall_cnt;
    p0  = start_cnt;
    waits = 0;
    flushed = 1'b0;
    issue = 1; is_mult = m; operand_a = a; operand_b = b; rd_in = rd;
    @(posedge clock); #1;
    chk("md_a", md_a, a);
    chk("md_b", md_b, b);
    chk("start_kind", {md_ctrl_mult, md_ctrl_div}, m ? 2'b10 : 2'b01);
    operand_a = $urandom; operand_b = $urandom; rd_in = 5'($urandom);
    md_ready = (lat > 1) && ($urandom_range(0, 1) == 1);
    md_result = $urandom;
    if (fl == 0) begin
      flush = 1;
      @(posedge clock); #1;
      flush = 0; issue = 0; md_ready = 0;
      flushed = 1'b1;
    end else begin
      forever begin
        @(posedge clock); #1;
        waits++;
        if (waits == 2) begin
          chk("md_a_hold", md_a, a);
          chk("md_b_hold", md_b, b);
        end
        md_ready = (waits == lat);
        md_result = md_ready ? res : $urandom;
        md_exception = md_ready ? ue : 1'($urandom);
        if (waits == fl) begin
          flush = 1;
          @(posedge clock); #1;
          flush = 0; issue = 0; md_ready = 0;
          flushed = 1'b1;
          break;
        end
        if (waits == lat || waits == TO) begin
          exc = (waits == lat) ? ue : 1'b1;
          e.rd = exc ? 5'd30 : rd;
          e.data = exc ? (m ? 32'd4 : 32'd5) : res;
          e.st = exc;
          if (exc || rd != 0) exp_q.push_back(e);
          @(posedge clock); #1;
          md_ready = 0;
          flush = fl_done;
          chk("stall_done", stall, 0);
          @(posedge clock); #1;
          flush = 0; issue = 0;
          break;
        end
      end
    end
    if (flushed) begin
      chk("busy_flush", busy, 0);
      chk("stall_flush", stall, 0);
      @(posedge clock); #1;
      md_ready = 1; md_result = res; md_exception = ue;
      @(posedge clock); #1;
      md_ready = 0;
      chk("busy_late_ready", busy, 0);
    end
    exp_stall = flushed ? 2 + fl : 2 + waits;
    chk("stall_cycles", stall_cnt - s0, exp_stall);
    chk("start_pulses", start_cnt - p0, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stall"}, stall, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ctrl"}, {md_ctrl_mult, md_ctrl_div}, 0);
    chk({tag, "_md_a"}, md_a, 0);
    chk({tag, "_md_b"}, md_b, 0);
    chk({tag, "_wbv"}, wb_valid, 0);
    chk({tag, "_wbrd"}, wb_rd, 0);
    chk({tag, "_wbdata"}, wb_data, 0);
    chk({tag, "_stwe"}, status_we, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int p0, lat, fl, mx;
    logic m;
    logic [31:0] a, b;
    #1 reset_n = 0;
    #2 chk_zero("reset");
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
    @(posedge clock); #1;

    run_op(1, 7, 6, 3, 16, -1, 0, 0);
    run_op(0, 5, 0, 9, 4, -1, 0, 0);
    run_op(1, 123, 456, 7, 1000, -1, 0, 0);
    run_op(0, 100, 7, 12, 5, 3, 0, 0);
    run_op(1, 3, 3, 0, 4, -1, 0, 0);
    run_op(0, 32'h8000_0000, 32'hffff_ffff, 4, 2, -1, 1, 0);
    run_op(1, 9, 9, 8, 1, -1, 0, 0);
    run_op(0, 100, 3, 6, 3, 0, 0, 0);

    p0 = start_cnt;
    run_op(0, 50, 5, 10, 3, -1, 0, 0);
    run_op(0, 77, 11, 11, 2, -1, 0, 0);
    chk("b2b_starts", start_cnt - p0, 2);

    issue = 1; flush = 1; is_mult = 1;
    #2 chk("flush_idle_stall", stall, 0);
    @(posedge clock); #1;
    issue = 0; flush = 0;
    chk("flush_idle_busy", busy, 0);

    issue = 1; is_mult = 0; operand_a = 32'h1234; operand_b = 3;
    rd_in = 5;
    @(posedge clock); #1;
    repeat (5) @(posedge clock);
    #2 reset_n = 0;
    #1 chk_zero("midreset");
    issue = 0; md_ready = 1; md_result = 32'hdead;
    @(posedge clock); #1;
    md_ready = 0;
    reset_n = 1;
    repeat (2) @(posedge clock);
    #1 chk("post_reset_busy", busy, 0);

    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      lat = ($urandom_range(0, 9) == 0) ? 100 : $urandom_range(1, 20);
      mx = (lat < TO) ? lat : TO;
      fl = ($urandom_range(0, 4) == 0) ? $urandom_range(0, mx) : -1;
      run_op(m, a, b, 5'($urandom), lat, fl, 1'($urandom),
             $urandom_range(0, 7) == 0);
    end

    repeat (3) @(posedge clock);
    #1 chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
